// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Optional build macro used by this block: DIV_FASTPATH_EN.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    // Counter must hold WIDTH-1 without wrapping
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_if.sv
// Execute-stage multi-cycle-unit handshake between execute (master) and divider (slave).
// Optional build macro affecting the slave's timing: DIV_FASTPATH_EN.
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             enable;
    logic             is_unsign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;

    modport master (
        output enable, is_unsign, a, b,
        input  quotient, remainder, done, busy
    );

    modport slave (
        input  enable, is_unsign, a, b,
        output quotient, remainder, done, busy
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial subtract.
// Optional build macro of the enclosing unit (not used here): DIV_FASTPATH_EN.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] prem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_prem,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // While divisor is non-zero prem < divisor, so a set top bit of trial means it went negative
    assign shifted   = {prem, dividend_msb};
    assign trial     = shifted - {1'b0, divisor};
    assign q_bit     = ~trial[WIDTH];
    assign next_prem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage; quotient feeds LO, remainder feeds HI.
// Define DIV_FASTPATH_EN to skip the iteration loop when b==0 or |a|<|b|.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] orig_a;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             sign_q;
    logic             sign_r;
    logic             div_zero;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             fast_skip;
    logic [WIDTH-1:0] step_prem;
    logic             step_q;

    assign neg_a = !bus.is_unsign && bus.a[WIDTH-1];
    assign neg_b = !bus.is_unsign && bus.b[WIDTH-1];
    assign abs_a = neg_a ? -bus.a : bus.a;
    assign abs_b = neg_b ? -bus.b : bus.b;

`ifdef DIV_FASTPATH_EN
    assign fast_skip = (bus.b == '0) || (abs_a < abs_b);
`else
    assign fast_skip = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem         (prem),
        .dividend_msb (dividend[WIDTH-1]),
        .divisor      (divisor),
        .next_prem    (step_prem),
        .q_bit        (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping enable in CALC/FIX is a flush: return to IDLE without a done pulse
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.enable) next_state = fast_skip ? FIX : CALC;
            CALC: begin
                if (!bus.enable) begin
                    next_state = IDLE;
                end else if (cnt == LAST) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = bus.enable ? DONE : IDLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            divisor     <= '0;
            dividend    <= '0;
            prem        <= '0;
            orig_a      <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            div_zero    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        divisor  <= abs_b;
                        orig_a   <= bus.a;
                        sign_q   <= neg_a ^ neg_b;
                        sign_r   <= neg_a;
                        div_zero <= (bus.b == '0);
                        cnt      <= '0;
                        prem     <= fast_skip ? abs_a : '0;
                        dividend <= fast_skip ? '0 : abs_a;
                    end
                end
                CALC: begin
                    prem     <= step_prem;
                    dividend <= {dividend[WIDTH-2:0], step_q};
                    cnt      <= cnt + CNT_W'(1);
                end
                // Quotient bits have fully replaced the dividend by now
                FIX: begin
                    if (bus.enable) begin
                        if (div_zero) begin
                            quotient_r  <= WIDTH'(DIV_ZERO_QUOT);
                            remainder_r <= orig_a;
                        end else begin
                            quotient_r  <= sign_q ? -dividend : dividend;
                            remainder_r <= sign_r ? -prem : prem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.done      = (state == DONE);
    assign bus.busy      = (state == CALC) || (state == FIX);
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: table of divisions plus abort, reset and back-to-back sequences.
// Expected latencies follow DIV_FASTPATH_EN when it is defined for the build.
module tb_div_unit;
    import div_pkg::*;

    localparam int W        = 32;
    localparam int FULL_LAT = W + 2;
    localparam int N_VECS   = 12;

    logic clk = 1'b0;
    logic rst;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         uns;
        logic         fast;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
    } vec_t;

    vec_t vecs [N_VECS];

    task automatic check_output(input string name, input logic [W-1:0] actual,
                                input logic [W-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h, want 0x%h", name, actual, expected);
        end
    endtask

    // Starts at a negedge; returns at the negedge of the done cycle (lat = -1 on timeout)
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                                  input bit keep_enable, output int lat,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        bus.enable    = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_unsign = uns;
        lat = -1;
        q   = '0;
        r   = '0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                q   = bus.quotient;
                r   = bus.remainder;
                break;
            end
        end
        if (!keep_enable) bus.enable = 1'b0;
    endtask

    task automatic step_and_check_idle(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_output({tag, "_done_low"}, W'(bus.done), W'(0));
        check_output({tag, "_busy_low"}, W'(bus.busy), W'(0));
    endtask

    initial begin
        int           lat;
        int           exp_lat;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           saw_done;

        vecs[0]  = '{"s_m7_2",      32'hFFFF_FFF9, 32'h2,         1'b0, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[1]  = '{"u_m7_2",      32'hFFFF_FFF9, 32'h2,         1'b1, 1'b0, 32'h7FFF_FFFC, 32'h1};
        vecs[2]  = '{"s_5_0",       32'h5,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 32'h5};
        vecs[3]  = '{"u_5_0",       32'h5,         32'h0,         1'b1, 1'b1, 32'hFFFF_FFFF, 32'h5};
        vecs[4]  = '{"s_ovf",       32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 32'h0};
        vecs[5]  = '{"u_3_10",      32'h3,         32'hA,         1'b1, 1'b1, 32'h0,         32'h3};
        vecs[6]  = '{"s_7_m2",      32'h7,         32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'h1};
        vecs[7]  = '{"s_m8_0",      32'hFFFF_FFF8, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF8};
        vecs[8]  = '{"u_max_1",     32'hFFFF_FFFF, 32'h1,         1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{"s_3_m10",     32'h3,         32'hFFFF_FFF6, 1'b0, 1'b1, 32'h0,         32'h3};
        vecs[10] = '{"s_m3_10",     32'hFFFF_FFFD, 32'hA,         1'b0, 1'b1, 32'h0,         32'hFFFF_FFFD};
        vecs[11] = '{"u_100_7",     32'd100,       32'd7,         1'b1, 1'b0, 32'd14,        32'd2};

        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_unsign = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_q",    bus.quotient,    '0);
        check_output("reset_r",    bus.remainder,   '0);
        check_output("reset_done", W'(bus.done),    W'(0));
        check_output("reset_busy", W'(bus.busy),    W'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < N_VECS; i++) begin
            exp_lat = FULL_LAT;
`ifdef DIV_FASTPATH_EN
            if (vecs[i].fast) exp_lat = 2;
`endif
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].uns, 1'b0, lat, q, r);
            check_output({vecs[i].name, "_lat"}, W'(lat), W'(exp_lat));
            check_output({vecs[i].name, "_q"},   q,       vecs[i].exp_q);
            check_output({vecs[i].name, "_r"},   r,       vecs[i].exp_r);
            step_and_check_idle(vecs[i].name);
        end

        // Flush mid-CALC: no done, previous results (100/7) must survive
        bus.enable    = 1'b1;
        bus.a         = 32'h1234;
        bus.b         = 32'h3;
        bus.is_unsign = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output("abort_busy_before", W'(bus.busy), W'(1));
        bus.enable = 1'b0;
        saw_done   = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check_output("abort_no_done", W'(saw_done),  W'(0));
        check_output("abort_busy",    W'(bus.busy),  W'(0));
        check_output("abort_keep_q",  bus.quotient,  32'd14);
        check_output("abort_keep_r",  bus.remainder, 32'd2);

        apply_stimulus(32'd9, 32'd3, 1'b1, 1'b0, lat, q, r);
        check_output("post_abort_lat", W'(lat), W'(FULL_LAT));
        check_output("post_abort_q",   q,       32'd3);
        check_output("post_abort_r",   r,       32'd0);
        step_and_check_idle("post_abort");

        // Synchronous reset mid-CALC clears the registered results
        bus.enable    = 1'b1;
        bus.a         = 32'h1234;
        bus.b         = 32'h3;
        bus.is_unsign = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("midrst_q",    bus.quotient,  '0);
        check_output("midrst_r",    bus.remainder, '0);
        check_output("midrst_done", W'(bus.done),  W'(0));
        check_output("midrst_busy", W'(bus.busy),  W'(0));
        bus.enable = 1'b0;
        rst        = 1'b0;
        @(negedge clk);

        // Back-to-back: enable stays high; second op starts in IDLE after the DONE cycle
        apply_stimulus(32'd20, 32'd4, 1'b1, 1'b1, lat, q, r);
        check_output("b2b1_lat", W'(lat), W'(FULL_LAT));
        check_output("b2b1_q",   q,       32'd5);
        check_output("b2b1_r",   r,       32'd0);
        apply_stimulus(32'd21, 32'd4, 1'b1, 1'b0, lat, q, r);
        check_output("b2b2_lat", W'(lat), W'(FULL_LAT + 1));
        check_output("b2b2_q",   q,       32'd5);
        check_output("b2b2_r",   r,       32'd1);
        step_and_check_idle("b2b2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
